// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM states and access bookkeeping for the data-memory LSU.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic [1:0] size;
        logic       is_unsigned;
        logic [1:0] addr_lo;
    } acc_t;

    // Halves must be 2-byte aligned, words 4-byte aligned; size 11 is never legal.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_ILL) ||
               ((size == SZ_H) && lo[0]) ||
               ((size == SZ_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a memory word and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = mem_word[8*addr_lo +: 8];
        lane_h = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
        case (size)
            SZ_B:    rdata = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SZ_H:    rdata = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default: rdata = mem_word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the pipeline and a registered-read data memory port.
// Latency: store/error response 1 cycle after accept, load response 2 cycles after accept.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_data
);

    lsu_state_t        state;
    acc_t              acc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              req_err;
    logic [3:0]        wmask_raw;
    logic [31:0]       load_data;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid & req_ready;
    assign req_err    = access_err(req_size, req_addr[1:0]);

    assign mem_addr = (state == IDLE) ? {req_addr[ADDR_W-1:2], 2'b00} : addr_q;

    always_comb begin
        case (req_size)
            SZ_B:    wmask_raw = 4'b0001 << req_addr[1:0];
            SZ_H:    wmask_raw = 4'b0011 << req_addr[1:0];
            default: wmask_raw = 4'b1111;
        endcase
    end

    always_comb begin
        case (req_size)
            SZ_B:    mem_wdata = {4{req_wdata[7:0]}};
            SZ_H:    mem_wdata = {2{req_wdata[15:0]}};
            default: mem_wdata = req_wdata;
        endcase
    end

    // Gated by resetn so no write strobe can reach the memory while reset is held.
    assign mem_wmask = (accept & req_we & ~req_err & resetn) ? wmask_raw : 4'b0000;

    lsu_load_align u_align (
        .mem_word    (mem_data),
        .addr_lo     (acc_q.addr_lo),
        .size        (acc_q.size),
        .is_unsigned (acc_q.is_unsigned),
        .rdata       (load_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            addr_q     <= '0;
            acc_q      <= '0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= {req_addr[ADDR_W-1:2], 2'b00};
                        acc_q      <= '{size: req_size, is_unsigned: req_unsigned,
                                        addr_lo: req_addr[1:0]};
                        resp_rdata <= 32'h0;
                        resp_err   <= req_err;
                        state      <= (req_err | req_we) ? RESP : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed and randomized bench for dmem_lsu against a byte-addressed reference memory.
module tb_dmem_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_data;
    logic [3:0]  mem_wmask;

    logic [7:0]  dmem    [0:16383];
    logic [7:0]  ref_mem [0:16383];

    int checks = 0;
    int errors = 0;

    dmem_lsu #(.ADDR_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wmask    (mem_wmask),
        .mem_wdata    (mem_wdata),
        .mem_data     (mem_data)
    );

    always #5 clk = ~clk;

    // Data memory with a registered read port and byte write enables.
    always @(posedge clk) begin
        mem_data <= {dmem[{mem_addr[13:2], 2'b11}], dmem[{mem_addr[13:2], 2'b10}],
                     dmem[{mem_addr[13:2], 2'b01}], dmem[{mem_addr[13:2], 2'b00}]};
        for (int i = 0; i < 4; i++)
            if (mem_wmask[i]) dmem[{mem_addr[13:2], 2'(i)}] <= mem_wdata[8*i +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [1:0] lo);
        int n = nbytes(sz);
        return (sz == SZ_ILL) || ((int'(lo) % n) != 0);
    endfunction

    function automatic logic [3:0] exp_mask(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] m = 4'b0000;
        for (int i = 0; i < nbytes(sz); i++) m[int'(lo) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        int n = nbytes(sz);
        for (int j = 0; j < 4; j++) w[8*j +: 8] = wd[8*(j % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [13:0] a, input logic [1:0] sz,
                                             input logic uns);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[14'(int'(a) + i)];
        if (!uns && v[8*n-1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic ref_store(input logic [13:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[14'(int'(a) + i)] = wd[8*i +: 8];
    endtask

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
    endtask

    // One complete access: accept-cycle checks, response latency, hold for `hold` cycles.
    task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic        e = ref_err(sz, addr[1:0]);
        logic [31:0] er;
        logic [31:0] r0;
        logic        e0;
        int          lat = 0;
        int          want_lat = (we || e) ? 1 : 2;
        @(negedge clk);
        drive_req(we, sz, uns, addr, wd);
        resp_ready = 1'b0;
        #1;
        chk("acc_req_ready", 32'(req_ready), 32'd1);
        chk("acc_mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("acc_wmask", 32'(mem_wmask), (we && !e) ? 32'(exp_mask(sz, addr[1:0])) : 32'd0);
        if (we && !e) chk("acc_wdata", mem_wdata, exp_wdata(sz, wd));
        er = 32'h0;
        if (!e && we) ref_store(addr[13:0], sz, wd);
        else if (!e) er = ref_load(addr[13:0], sz, uns);
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
            chk("wait_wmask", 32'(mem_wmask), 32'd0);
        end
        chk("resp_latency", 32'(lat), 32'(want_lat));
        chk("resp_err", 32'(resp_err), 32'(e));
        chk("resp_rdata", resp_rdata, er);
        r0 = resp_rdata;
        e0 = resp_err;
        // Offer a competing store while the response is pending; it must not be taken.
        drive_req(1'b1, SZ_W, 1'b0, 32'h0, 32'hBAD0BAD0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, r0);
            chk("hold_err", 32'(resp_err), 32'(e0));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_wmask", 32'(mem_wmask), 32'd0);
        end
        resp_ready = 1'b1;
        #1;
        chk("consume_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
    endtask

    localparam int NT = 16;
    logic        t_we [NT];
    logic [1:0]  t_sz [NT];
    logic        t_uns[NT];
    logic [31:0] t_ad [NT];
    logic [31:0] t_wd [NT];
    logic [32:0] exp_q[$];

    initial begin
        int acc_idx;
        int cyc;
        int next_acc;
        logic [32:0] ex;
        logic        te;

        resetn = 1'b0;
        resp_ready = 1'b0;
        drive_req(1'b1, SZ_W, 1'b0, 32'h0, 32'h12345678);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_wmask", 32'(mem_wmask), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 64; i++) do_access(1'b1, SZ_W, 1'b0, 32'(i * 4), $urandom, 0);

        // Byte store lands in the top lane with the byte replicated.
        do_access(1'b1, SZ_B, 1'b0, 32'h1003, 32'h000000A5, 0);
        do_access(1'b1, SZ_W, 1'b0, 32'h2000, 32'h80011234, 0);
        do_access(1'b0, SZ_H, 1'b0, 32'h2002, 32'h0, 5);
        do_access(1'b0, SZ_H, 1'b1, 32'h2002, 32'h0, 0);
        do_access(1'b0, SZ_B, 1'b0, 32'h1003, 32'h0, 1);
        do_access(1'b0, SZ_W, 1'b0, 32'h0006, 32'h0, 0);
        do_access(1'b1, SZ_ILL, 1'b0, 32'h0008, 32'hFFFFFFFF, 0);
        do_access(1'b1, SZ_H, 1'b0, 32'h0011, 32'hFFFFFFFF, 0);

        // Reset while the load is waiting for memory data.
        @(negedge clk);
        drive_req(1'b0, SZ_W, 1'b0, 32'h40, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rdwait_no_resp", 32'(resp_valid), 32'd0);
        resetn = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_idle", 32'(req_ready), 32'd1);
        chk("midrst_wmask", 32'(mem_wmask), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("after_rst_no_resp", 32'(resp_valid), 32'd0);
            chk("after_rst_ready", 32'(req_ready), 32'd1);
        end
        do_access(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        do_access(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 0);

        for (int i = 0; i < 40; i++)
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 2));

        // Streaming with resp_ready held high: accepts spaced 2 (store/error) or 3 (load) cycles.
        for (int i = 0; i < NT; i++) begin
            t_we[i]  = 1'($urandom_range(0, 1));
            t_sz[i]  = 2'($urandom_range(0, 3));
            t_uns[i] = 1'($urandom_range(0, 1));
            t_ad[i]  = 32'($urandom_range(0, 255));
            t_wd[i]  = $urandom;
        end
        acc_idx = 0;
        cyc = 0;
        next_acc = 0;
        while ((acc_idx < NT || exp_q.size() > 0) && cyc < 200) begin
            @(negedge clk);
            resp_ready = 1'b1;
            if (acc_idx < NT) drive_req(t_we[acc_idx], t_sz[acc_idx], t_uns[acc_idx],
                                        t_ad[acc_idx], t_wd[acc_idx]);
            else req_valid = 1'b0;
            #1;
            if (resp_valid) begin
                if (exp_q.size() > 0) begin
                    ex = exp_q.pop_front();
                    chk("tput_err", 32'(resp_err), 32'(ex[32]));
                    chk("tput_rdata", resp_rdata, ex[31:0]);
                end else begin
                    chk("tput_spurious_resp", 32'(resp_valid), 32'd0);
                end
            end
            if (acc_idx < NT) begin
                chk("tput_req_ready", 32'(req_ready), 32'(cyc == next_acc));
                if (req_ready) begin
                    te = ref_err(t_sz[acc_idx], t_ad[acc_idx][1:0]);
                    ex = {te, 32'h0};
                    if (!te && t_we[acc_idx]) ref_store(t_ad[acc_idx][13:0], t_sz[acc_idx], t_wd[acc_idx]);
                    else if (!te) ex[31:0] = ref_load(t_ad[acc_idx][13:0], t_sz[acc_idx], t_uns[acc_idx]);
                    exp_q.push_back(ex);
                    next_acc = cyc + ((!te && !t_we[acc_idx]) ? 3 : 2);
                    acc_idx++;
                end
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        chk("tput_issued", 32'(acc_idx), 32'(NT));
        chk("tput_drained", 32'(exp_q.size()), 32'd0);

        // Every reference byte written so far must match the memory the DUT drove.
        for (int a = 0; a < 16384; a++)
            if (dmem[a] !== ref_mem[a]) chk("mem_image", 32'(dmem[a]), 32'(ref_mem[a]));
        checks++;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of req_addr and mem_addr.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the pipeline presents an access.
REQ-005 SHALL have port req_ready, output, 1 bit: the LSU accepts the access this cycle.
REQ-006 SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1 bit: the load zero-extends instead of sign-extending.
REQ-009 SHALL have port req_addr, input, ADDR_W bits: the byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: a completion is presented.
REQ-012 SHALL have port resp_ready, input, 1 bit: the pipeline consumes the completion.
REQ-013 SHALL have port resp_rdata, output, 32 bits: the aligned and extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit: misaligned access or illegal size.
REQ-015 SHALL have port mem_addr, output, ADDR_W bits: the word address to the data-memory port, with bits [1:0]=00.
REQ-016 SHALL have port mem_wmask, output, 4 bits: per-byte write enables.
REQ-017 SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-018 SHALL have port mem_data, input, 32 bits: the memory's registered read word, valid one cycle after mem_addr is sampled.

Function
REQ-019 SHALL implement the states IDLE, RD_WAIT and RESP.
REQ-020 SHALL assert req_ready only in IDLE; an access is accepted on req_valid & req_ready.
REQ-021 SHALL, in IDLE, drive mem_addr combinationally as {req_addr[ADDR_W-1:2],2'b00}; in other states it SHALL hold the registered address of the accepted access.
REQ-022 SHALL drive mem_wmask nonzero only in the acceptance cycle of a legal, aligned store; it SHALL be 0000 in every other cycle.
REQ-023 SHALL generate the write mask as follows: byte gives 0001<<addr[1:0]; half gives 0011<<addr[1:0]; word gives 1111.
REQ-024 SHALL replicate mem_wdata as follows: byte gives {4{wdata[7:0]}}; half gives {2{wdata[15:0]}}; word gives wdata.
REQ-025 SHALL treat as an error a half with addr[0]=1, a word with addr[1:0]!=00, or size 11; such an access writes nothing and goes to RESP with resp_err=1 and resp_rdata=0.
REQ-026 SHALL take an aligned load from IDLE to RD_WAIT; in RD_WAIT it SHALL extract the lane from mem_data by the registered addr[1:0] and size, extend it, register the result into resp_rdata, and go to RESP.
REQ-027 SHALL take an aligned store from IDLE to RESP with resp_rdata=0 and resp_err=0.
REQ-028 SHALL assert resp_valid only in RESP; resp_rdata and resp_err SHALL stay stable until resp_ready, then the LSU returns to IDLE.
REQ-029 SHALL give a load resp_valid 2 cycles after acceptance, and a store or error resp_valid 1 cycle after acceptance.
REQ-030 SHALL sustain back-to-back accesses at one per 2 cycles for stores, or one per 3 cycles for loads, when resp_ready is held at 1.
REQ-031 SHALL NOT accept a new request while resp_valid=1, even if resp_ready=1 in the same cycle.

Reset
REQ-032 SHALL, while resetn=0, force the state to IDLE and set resp_valid=0, resp_rdata=0, resp_err=0, the registered mem_addr to 0, and mem_wmask to 0000.
REQ-033 SHALL, on a reset asserted mid-access, abandon the access with no write and no response; after deassertion req_ready=1.

Structure
REQ-034 SHALL place the size encodings (SZ_B, SZ_H, SZ_W) and the state enum in shared package lsu_pkg.
REQ-035 SHALL place load lane extraction and extension in the combinational sub-module lsu_load_align.

Verification
REQ-036 SHALL cover: a store of byte 0xA5 at 0x1003 -> in the accept cycle mem_wmask=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000; resp one cycle later with err=0.
REQ-037 SHALL cover: a signed half load at 0x2002 with mem_data=0x8001_1234 -> resp_rdata=0xFFFF8001 two cycles after acceptance; the unsigned variant gives 0x00008001.
REQ-038 SHALL cover: a word load at 0x0006 -> mem_wmask stays 0000, and next cycle resp_err=1 with resp_rdata=0.
REQ-039 SHALL cover: resp_ready held at 0 for 5 cycles after a load response -> resp_rdata and resp_err stay constant, req_ready=0, and no mem_wmask activity.
REQ-040 SHALL cover: resetn pulsed low while in RD_WAIT -> resp_valid=0 and the state is IDLE; a following word store of 0xDEADBEEF at 0x10 writes the mask 1111.
